// File: rtl/serial_code_receiver_pkg.sv
// Shared types and defaults for the serial code receiver.
package serial_code_pkg;

  // Receiver FSM states; also exported on the debug port.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    OUTPUT  = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam int         DEFAULT_N        = 4;
  localparam logic [3:0] DEFAULT_PASSWORD = 4'b1101;

endpackage

// File: rtl/serial_code_receiver_if.sv
// Bus bundle for the serial code receiver.
//
// Handshakes: both channels use strict valid/ready. A transfer happens on a
// rising clk edge where valid && ready are both high. The source must hold
// its data stable while valid is high and ready is low; the sink may change
// ready freely. On the serial side the receiver is the sink (s_ready); on
// the parallel side it is the source (p_valid/p_data).
interface serial_code_receiver_if #(
  parameter int N = 4
) ();
  logic         s_data;
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] p_data;
  logic         p_valid;
  logic         p_ready;
  logic         unlock;
  logic         pwd_incorrect;
  logic         locked;

  // Upstream sender / downstream consumer side.
  modport master (
    output s_data, s_valid, p_ready,
    input  s_ready, p_data, p_valid, unlock, pwd_incorrect, locked
  );

  // Receiver side.
  modport slave (
    input  s_data, s_valid, p_ready,
    output s_ready, p_data, p_valid, unlock, pwd_incorrect, locked
  );
endinterface

// File: rtl/serial_code_receiver_s2p_deserializer.sv
// Serial-to-parallel assembler: places accepted bits LSB first and flags the
// N-th bit. o_word already includes the bit accepted this cycle so the top
// can register the complete word on o_word_done.
module s2p_deserializer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_data,
  input  logic         i_valid,
  output logic [N-1:0] o_word,
  output logic         o_word_done
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] r_bit_cnt;
  logic [N-1:0]  r_word;
  logic          w_accept;
  logic          w_last;

  assign w_accept    = i_en && i_valid;
  assign w_last      = (r_bit_cnt == CW'(N - 1));
  assign o_word_done = w_accept && w_last;

  // Merge the incoming bit into the partial word at its position.
  always_comb begin
    o_word = r_word;
    if (w_accept) begin
      o_word[r_bit_cnt] = i_data;
    end
  end

  // Partial word and bit position; the count wraps after the N-th bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_word    <= '0;
    end else if (w_accept) begin
      r_word    <= o_word;
      r_bit_cnt <= w_last ? '0 : r_bit_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/serial_code_receiver.sv
// Serial code receiver top: collects N-bit words LSB first, compares them
// with PASSWORD, presents each word on a parallel valid/ready port and
// pulses unlock or pwd_incorrect on the first presentation cycle.
// Build option FAIL_LOCKOUT_EN: count consecutive mismatches and enter a
// LOCKOUT period of LOCKOUT_CYCLES clocks after MAX_FAIL of them.
module serial_code_receiver
  import serial_code_pkg::*;
#(
  parameter int         N              = DEFAULT_N,
  parameter logic [N-1:0] PASSWORD     = N'(DEFAULT_PASSWORD),
  parameter int         MAX_FAIL       = 3,
  parameter int         LOCKOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_code_receiver_if.slave  bus,
  output state_t                 o_dbg_state
);
  state_t       r_state;
  state_t       w_next;
  logic         r_run;
  logic [N-1:0] r_p_data;
  logic         r_unlock;
  logic         r_pwd_incorrect;
  logic         w_s_ready;
  logic [N-1:0] w_word;
  logic         w_word_done;
  logic         w_match;

  // r_run keeps s_ready low during reset and for the cycle rst falls.
  assign w_s_ready = r_run && (r_state == COLLECT);
  assign w_match   = (w_word == PASSWORD);

  s2p_deserializer #(.N(N)) u_s2p (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_s_ready),
    .i_data      (bus.s_data),
    .i_valid     (bus.s_valid),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

`ifdef FAIL_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  logic [FW-1:0] r_fail_cnt;
  logic [LW-1:0] r_lock_cnt;
`endif

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      COLLECT: begin
        if (w_word_done) w_next = OUTPUT;
      end
      OUTPUT: begin
        if (bus.p_ready) begin
`ifdef FAIL_LOCKOUT_EN
          w_next = (r_fail_cnt == FW'(MAX_FAIL)) ? LOCKOUT : COLLECT;
`else
          w_next = COLLECT;
`endif
        end
      end
      LOCKOUT: begin
`ifdef FAIL_LOCKOUT_EN
        if (r_lock_cnt == '0) w_next = COLLECT;
`else
        w_next = COLLECT;
`endif
      end
      default: w_next = COLLECT;
    endcase
  end

  // State register plus the post-reset run flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  end

  // Word capture and one-cycle verdict pulses aligned with the first OUTPUT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_data        <= '0;
      r_unlock        <= 1'b0;
      r_pwd_incorrect <= 1'b0;
    end else if (w_word_done) begin
      r_p_data        <= w_word;
      r_unlock        <= w_match;
      r_pwd_incorrect <= !w_match;
    end else begin
      r_unlock        <= 1'b0;
      r_pwd_incorrect <= 1'b0;
    end
  end

`ifdef FAIL_LOCKOUT_EN
  // Consecutive-mismatch count, updated together with the verdict pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fail_cnt <= '0;
    end else if (w_word_done) begin
      if (w_match)                            r_fail_cnt <= '0;
      else if (r_fail_cnt != FW'(MAX_FAIL))   r_fail_cnt <= r_fail_cnt + FW'(1);
    end else if (r_state == LOCKOUT && r_lock_cnt == '0) begin
      r_fail_cnt <= '0;
    end
  end

  // Lockout down-counter: loaded on entry, LOCKOUT lasts LOCKOUT_CYCLES clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_cnt <= '0;
    end else if (r_state == OUTPUT && w_next == LOCKOUT) begin
      r_lock_cnt <= LW'(LOCKOUT_CYCLES - 1);
    end else if (r_state == LOCKOUT && r_lock_cnt != '0) begin
      r_lock_cnt <= r_lock_cnt - LW'(1);
    end
  end

  assign bus.locked = (r_state == LOCKOUT);
`else
  // Lockout parameters are inert here; the expression folds to constant 0.
  assign bus.locked = 1'b0 & (MAX_FAIL < 0) & (LOCKOUT_CYCLES < 0);
`endif

  assign bus.s_ready       = w_s_ready;
  assign bus.p_valid       = (r_state == OUTPUT);
  assign bus.p_data        = r_p_data;
  assign bus.unlock        = r_unlock;
  assign bus.pwd_incorrect = r_pwd_incorrect;
  assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_serial_code_receiver.sv
// Bench for serial_code_receiver: directed scenarios followed by random words.
module tb_serial_code_receiver;
  import serial_code_pkg::*;

  localparam int         N              = 4;
  localparam logic [N-1:0] PASSWORD     = 4'b1101;
  localparam int         MAX_FAIL       = 3;
  localparam int         LOCKOUT_CYCLES = 16;
  localparam int         STALL_LIMIT    = 300;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_code_receiver_if #(.N(N)) bus_if ();

  serial_code_receiver #(
    .N              (N),
    .PASSWORD       (PASSWORD),
    .MAX_FAIL       (MAX_FAIL),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [N-1:0] exp_q[$];
  logic         exp_unlock_q[$];
  logic         exp_lock_q[$];
  int           errors = 0;
  int           checks = 0;
  int           model_fail = 0;
  int           last_acc_cyc = 0;

  // p_ready control
  bit pr_random = 0;
  bit hold_next = 0;
  int pr_hold_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a word unlocks iff it equals PASSWORD; MAX_FAIL
  // consecutive mismatches predict a lockout after that word is taken.
  task automatic push_expect(input logic [N-1:0] w);
    logic m;
    logic l;
    m = (w == PASSWORD);
    l = 1'b0;
`ifdef FAIL_LOCKOUT_EN
    if (m) model_fail = 0;
    else if (model_fail < MAX_FAIL) model_fail++;
    if (model_fail == MAX_FAIL) begin
      l = 1'b1;
      model_fail = 0;
    end
`endif
    exp_q.push_back(w);
    exp_unlock_q.push_back(m);
    exp_lock_q.push_back(l);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b, input int gmin, input int gmax);
    int t;
    t = 0;
    bus_if.s_data  = b;
    bus_if.s_valid = 1'b1;
    @(negedge clk);
    while (!bus_if.s_ready && t < STALL_LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (t >= STALL_LIMIT) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout: got s_ready=0 for %0d cycles expected 1", t);
      bus_if.s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_acc_cyc   = cyc;
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = 1'($urandom_range(0, 1));
    repeat ($urandom_range(gmin, gmax)) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [N-1:0] w, input int gmin, input int gmax);
    push_expect(w);
    for (int i = 0; i < N; i++) send_bit(w[i], gmin, gmax);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"},       bus_if.s_ready, 0);
    check({tag, "_p_valid"},       bus_if.p_valid, 0);
    check({tag, "_p_data"},        bus_if.p_data, 0);
    check({tag, "_unlock"},        bus_if.unlock, 0);
    check({tag, "_pwd_incorrect"}, bus_if.pwd_incorrect, 0);
    check({tag, "_locked"},        bus_if.locked, 0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    bus_if.s_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_fail = 0;
    @(negedge clk);
    check("rst_release_s_ready", bus_if.s_ready, 0);
    @(negedge clk);
    check("collect_s_ready", bus_if.s_ready, 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor + p_ready driver ----------------
  bit           pending = 0;
  bit           post_xfer = 0;
  logic         post_lock = 0;
  logic         cur_lock = 0;
  logic [N-1:0] held_word = '0;
  int           lock_run = 0;

  always @(negedge clk) begin
    if (rst) begin
      bus_if.p_ready = 1'b0;
      pending   = 0;
      post_xfer = 0;
      lock_run  = 0;
    end else begin
      if (bus_if.p_valid && !pending && hold_next) begin
        pr_hold_low = 5;
        hold_next   = 0;
      end
      if (pr_hold_low > 0) begin
        bus_if.p_ready = 1'b0;
        pr_hold_low--;
      end else begin
        bus_if.p_ready = pr_random ? ($urandom_range(0, 3) != 0) : 1'b1;
      end

      if (post_xfer) begin
        check("p_valid_after_xfer", bus_if.p_valid, 0);
        check("locked_after_xfer", bus_if.locked, post_lock);
        post_xfer = 0;
      end

      if (bus_if.locked) begin
        lock_run++;
        check("s_ready_in_lockout", bus_if.s_ready, 0);
      end else if (lock_run > 0) begin
        check("lockout_len", lock_run, LOCKOUT_CYCLES);
        lock_run = 0;
      end

      if (bus_if.p_valid) begin
        check("s_ready_in_output", bus_if.s_ready, 0);
        if (!pending) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got p_data=%0h expected no word", bus_if.p_data);
            held_word = bus_if.p_data;
            cur_lock  = 1'b0;
          end else begin
            held_word = exp_q.pop_front();
            cur_lock  = exp_lock_q.pop_front();
            begin
              logic u;
              u = exp_unlock_q.pop_front();
              check("p_data", bus_if.p_data, held_word);
              check("unlock", bus_if.unlock, u);
              check("pwd_incorrect", bus_if.pwd_incorrect, !u);
              check("latency", cyc, last_acc_cyc);
            end
          end
          pending = 1;
        end else begin
          check("p_data_stable", bus_if.p_data, held_word);
          check("pulse_one_cycle", {bus_if.unlock, bus_if.pwd_incorrect}, 0);
        end
        if (bus_if.p_ready) begin
          pending   = 0;
          post_xfer = 1;
          post_lock = cur_lock;
        end
      end else begin
        if (pending) begin
          checks++;
          errors++;
          $display("FAIL p_valid_dropped: got p_valid=0 expected 1 until transfer");
          pending = 0;
        end
        check("no_pulse_idle", {bus_if.unlock, bus_if.pwd_incorrect}, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    logic [N-1:0] w;
    bus_if.s_data  = 1'b0;
    bus_if.s_valid = 1'b0;

    do_reset(3);

    // Match, back-to-back bits.
    send_word(4'b1101, 0, 0);
    // Mismatch.
    send_word(4'b1100, 0, 0);
    // Gapped bits then 5 stall cycles on the parallel side.
    hold_next = 1;
    send_word(4'b1101, 2, 2);
    // Three mismatches (lockout when enabled), then a match.
    repeat (3) send_word(4'b1001, 0, 1);
    send_word(4'b1101, 0, 0);

    // Reset mid-word discards the partial word.
    send_bit(1'b1, 0, 0);
    send_bit(1'b0, 0, 0);
    do_reset(1);
    send_word(4'b1101, 0, 0);

    // Repeated all-zero words.
    repeat (4) send_word(4'b0000, 0, 0);

    // Random phase.
    pr_random = 1;
    for (int i = 0; i < 40; i++) begin
      w = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 3) == 0) w = PASSWORD;
      send_word(w, 0, 2);
    end

    // Drain.
    t = 0;
    while ((exp_q.size() > 0 || pending || post_xfer || bus_if.locked) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d words outstanding expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
